// File: rtl/seq_detector_prog.sv
// rtl/seq_detector_prog.sv - runtime-programmable serial pattern detector with saturating match count
// Shifts valid-qualified bits into a history register and compares the low len bits to the pattern.
module seq_detector_prog #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   input  logic               in_valid,
   input  logic               in_bit,
   output logic               detected,
   output logic [CNT_W-1:0]   match_count,
   output logic               cfg_err
);

   logic [MAX_LEN-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               overlap_q, overlap_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               detected_q, detected_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               cfg_err_q, cfg_err_d;

   logic [MAX_LEN-1:0] next_hist;
   logic [MAX_LEN-1:0] len_mask;
   logic [LEN_W:0]     fill_inc;
   logic               hit;

   always_comb begin
      next_hist = {hist_q[MAX_LEN-2:0], in_bit};
      fill_inc  = {1'b0, fill_q} + 1'b1;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < int'(len_q));
      end
      // Only the low len bits take part; history above the pattern is don't-care.
      hit = in_valid && !cfg_load && !cfg_err_q
            && (fill_inc >= {1'b0, len_q})
            && (((next_hist ^ pattern_q) & len_mask) == '0);
   end

   always_comb begin
      pattern_d  = pattern_q;
      len_d      = len_q;
      overlap_d  = overlap_q;
      hist_d     = hist_q;
      fill_d     = fill_q;
      detected_d = 1'b0;
      cfg_err_d  = cfg_err_q;
      count_d    = count_q;

      if (cfg_load) begin
         pattern_d = cfg_pattern;
         len_d     = cfg_len;
         overlap_d = cfg_overlap;
         hist_d    = '0;
         fill_d    = '0;
         cfg_err_d = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
      end else begin
         detected_d = hit;
         if (in_valid) begin
            hist_d = next_hist;
            fill_d = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_inc[LEN_W-1:0];
            if (hit && !overlap_q) begin
               fill_d = '0;
            end
         end
      end

      if (cnt_clr) begin
         count_d = '0;
      end else if (hit && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern_q  <= '0;
         len_q      <= '0;
         overlap_q  <= 1'b0;
         hist_q     <= '0;
         fill_q     <= '0;
         detected_q <= 1'b0;
         count_q    <= '0;
         cfg_err_q  <= 1'b1;
      end else begin
         pattern_q  <= pattern_d;
         len_q      <= len_d;
         overlap_q  <= overlap_d;
         hist_q     <= hist_d;
         fill_q     <= fill_d;
         detected_q <= detected_d;
         count_q    <= count_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign detected    = detected_q;
   assign match_count = count_q;
   assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb/tb_seq_detector_prog.sv - scoreboard bench for seq_detector_prog
// Driver pushes hand-computed expectations per cycle; monitor pops and compares on the falling edge.
module tb_seq_detector_prog;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               cnt_clr;
   logic               in_valid;
   logic               in_bit;
   logic               detected;
   logic [CNT_W-1:0]   match_count;
   logic               cfg_err;

   seq_detector_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cnt_clr     (cnt_clr),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .detected    (detected),
      .match_count (match_count),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             det;
      logic [CNT_W-1:0] cnt;
      logic             err;
      logic [7:0]       tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (detected !== e.det) begin
               n_bad++;
               $display("FAIL detected step %0d: got %b want %b", e.tag, detected, e.det);
            end
            n_cmp++;
            if (match_count !== e.cnt) begin
               n_bad++;
               $display("FAIL match_count step %0d: got %0d want %0d", e.tag, match_count, e.cnt);
            end
            n_cmp++;
            if (cfg_err !== e.err) begin
               n_bad++;
               $display("FAIL cfg_err step %0d: got %b want %b", e.tag, cfg_err, e.err);
            end
         end
      end
   end

   int step_no = 0;

   task automatic step(input logic v, input logic b, input logic ld, input logic clr,
                       input logic rp, input logic ed, input logic [CNT_W-1:0] ec,
                       input logic ee);
      exp_t e;
      @(negedge clk);
      in_valid = v;
      in_bit   = b;
      cfg_load = ld;
      cnt_clr  = clr;
      if (rp) begin
         rst_n = 1'b0;
         #2;
         rst_n = 1'b1;
      end
      @(posedge clk);
      step_no++;
      e.det = ed;
      e.cnt = ec;
      e.err = ee;
      e.tag = 8'(step_no);
      exp_q.push_back(e);
   endtask

   task automatic set_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                          input logic ovl);
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_load = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
      set_cfg(8'h00, 4'd0, 1'b0);
      step(0,0,0,0,0, 0,2'd0,1);
      @(negedge clk) rst_n = 1'b1;
      // v  b  ld clr rp  det cnt err
      step(1,1,0,0,0, 0,2'd0,1);

      // overlapping 0101
      set_cfg(8'h05, 4'd4, 1'b1);
      step(0,0,1,0,0, 0,2'd0,0);
      step(1,0,0,0,0, 0,2'd0,0);
      step(1,1,0,0,0, 0,2'd0,0);
      step(1,0,0,0,0, 0,2'd0,0);
      step(1,1,0,0,0, 1,2'd1,0);
      step(1,0,0,0,0, 0,2'd1,0);
      step(1,1,0,0,0, 1,2'd2,0);
      step(0,0,0,1,0, 0,2'd0,0);

      // non-overlapping 0101
      set_cfg(8'h05, 4'd4, 1'b0);
      step(0,0,1,0,0, 0,2'd0,0);
      step(1,0,0,0,0, 0,2'd0,0);
      step(1,1,0,0,0, 0,2'd0,0);
      step(1,0,0,0,0, 0,2'd0,0);
      step(1,1,0,0,0, 1,2'd1,0);
      step(1,0,0,0,0, 0,2'd1,0);
      step(1,1,0,0,0, 0,2'd1,0);
      step(1,0,0,0,0, 0,2'd1,0);
      step(1,1,0,0,0, 1,2'd2,0);
      step(0,0,0,1,0, 0,2'd0,0);

      // len 3 pattern 110 with gaps; gap bits are 0 and must not shift in
      set_cfg(8'h06, 4'd3, 1'b1);
      step(0,0,1,0,0, 0,2'd0,0);
      step(1,1,0,0,0, 0,2'd0,0);
      step(0,0,0,0,0, 0,2'd0,0);
      step(1,1,0,0,0, 0,2'd0,0);
      step(0,0,0,0,0, 0,2'd0,0);
      step(1,0,0,0,0, 1,2'd1,0);
      step(0,0,0,0,0, 0,2'd1,0);
      step(0,0,0,1,0, 0,2'd0,0);

      // len 1, counter saturation at 3, clear beats hit
      set_cfg(8'h01, 4'd1, 1'b1);
      step(0,0,1,0,0, 0,2'd0,0);
      step(1,1,0,0,0, 1,2'd1,0);
      step(1,1,0,0,0, 1,2'd2,0);
      step(1,1,0,0,0, 1,2'd3,0);
      step(1,1,0,0,0, 1,2'd3,0);
      step(1,1,0,0,0, 1,2'd3,0);
      step(1,1,0,1,0, 1,2'd0,0);
      step(0,0,0,0,0, 0,2'd0,0);

      // illegal lengths 0 and 9 block detection of A5
      set_cfg(8'hA5, 4'd0, 1'b1);
      step(0,0,1,0,0, 0,2'd0,1);
      for (int i = 7; i >= 0; i--) step(1,cfg_pattern[i],0,0,0, 0,2'd0,1);
      set_cfg(8'hA5, 4'd9, 1'b1);
      step(0,0,1,0,0, 0,2'd0,1);
      for (int i = 7; i >= 0; i--) step(1,cfg_pattern[i],0,0,0, 0,2'd0,1);
      step(1,1,0,0,0, 0,2'd0,1);
      set_cfg(8'hA5, 4'd8, 1'b1);
      step(0,0,1,0,0, 0,2'd0,0);
      for (int i = 7; i >= 1; i--) step(1,cfg_pattern[i],0,0,0, 0,2'd0,0);
      step(1,1,0,0,0, 1,2'd1,0);
      step(1,0,0,0,0, 0,2'd1,0);

      // completing bit coincides with cfg_load: bit dropped, history flushed
      set_cfg(8'h05, 4'd4, 1'b1);
      step(0,0,1,0,0, 0,2'd1,0);
      step(1,0,0,0,0, 0,2'd1,0);
      step(1,1,0,0,0, 0,2'd1,0);
      step(1,0,0,0,0, 0,2'd1,0);
      step(1,1,1,0,0, 0,2'd1,0);
      step(1,1,0,0,0, 0,2'd1,0);

      // async reset pulse between edges after 3 of 4 bits
      step(0,0,1,0,0, 0,2'd1,0);
      step(1,0,0,0,0, 0,2'd1,0);
      step(1,1,0,0,0, 0,2'd1,0);
      step(1,0,0,0,0, 0,2'd1,0);
      step(0,0,0,0,1, 0,2'd0,1);
      step(1,1,0,0,0, 0,2'd0,1);
      step(0,0,0,0,0, 0,2'd0,1);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
